// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared constants, timer state type and lane-mask helper for data_ram_resp.
package data_ram_pkg;
    localparam logic [3:0] MMIO_BASE          = 4'hF;
    localparam logic [7:0] LED_OFF            = 8'h00;
    localparam logic [7:0] CYCLE_OFF          = 8'h04;
    localparam logic [7:0] TIMER_OFF          = 8'h08;
    localparam logic [7:0] STATUS_OFF         = 8'h0C;
    localparam int         STATUS_EXPIRED_BIT = 0;

    typedef enum logic {IDLE, RUN} timer_state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
endpackage

// File: rtl/data_ram_timer.sv
// data_ram_timer: 32-bit loadable down-counter with sticky expiry flag on the 1->0 step.
module data_ram_timer
    import data_ram_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        clear_i,
    output logic [31:0] count_o,
    output logic        expired_o
);
    timer_state_e state_q, state_d;
    logic [31:0]  count_q, count_d;
    logic         expired_q, expired_d, fire;

    // A load in the expiry cycle wins; an expiry beats a simultaneous clear.
    always_comb begin
        fire      = state_q == RUN && count_q == 32'd1;
        state_d   = load_i ? (load_val_i != '0 ? RUN : IDLE) : (fire ? IDLE : state_q);
        count_d   = load_i ? load_val_i : (state_q == RUN ? count_q - 32'd1 : count_q);
        expired_d = (fire && !load_i) || (expired_q && !clear_i);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = expired_q;
endmodule

// File: rtl/data_ram_resp.sv
// data_ram_resp: word-organised RAM serving the core's data port, combinational reads.
// Define DATA_RAM_MMIO_EN to add the LED / cycle counter / timer window at 0xFxxx_xxxx.
module data_ram_resp
    import data_ram_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int LED_W  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ram_addr_i,
    input  logic [31:0]      ram_data_i,
    input  logic             ram_we_i,
    input  logic [3:0]       ram_sel_i,
    input  logic [3:0]       ram_ce_i,
    output logic [31:0]      ram_data_o,
    output logic [LED_W-1:0] led_o,
    output logic             irq_o
);
    logic [31:0]       mem_q [2**RAM_AW];
    logic [RAM_AW-1:0] idx;
    logic [31:0]       mask, rd_word;
    logic              acc_vld, mmio_sel, ram_wr, unused_bits;

    assign acc_vld     = |ram_ce_i;
    assign idx         = ram_addr_i[RAM_AW+1:2];
    assign mask        = lane_mask(ram_sel_i);
    assign ram_wr      = clr && acc_vld && ram_we_i && !mmio_sel;
    assign unused_bits = ^{ram_addr_i[31:RAM_AW+2], ram_addr_i[1:0]};

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_wr)
            mem_q[idx] <= (mem_q[idx] & ~mask) | (ram_data_i & mask);
    end

`ifdef DATA_RAM_MMIO_EN
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cycle_q, cycle_d, mmio_rd, tmr_count;
    logic [7:0]       off;
    logic             mmio_wr, tmr_expired;

    assign mmio_sel = ram_addr_i[31:28] == MMIO_BASE;
    assign off      = ram_addr_i[7:0];
    assign mmio_wr  = acc_vld && ram_we_i && mmio_sel;

    always_comb begin
        led_d   = (mmio_wr && off == LED_OFF) ? LED_W'((32'(led_q) & ~mask) | (ram_data_i & mask)) : led_q;
        cycle_d = cycle_q + 32'd1;
        mmio_rd = off == LED_OFF    ? 32'(led_q) :
                  off == CYCLE_OFF  ? cycle_q :
                  off == TIMER_OFF  ? tmr_count :
                  off == STATUS_OFF ? 32'(tmr_expired) << STATUS_EXPIRED_BIT : '0;
        rd_word = mmio_sel ? mmio_rd : mem_q[idx];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

    data_ram_timer u_timer (
        .clk        (clk),
        .clr        (clr),
        .load_i     (mmio_wr && off == TIMER_OFF),
        .load_val_i (ram_data_i),
        .clear_i    (mmio_wr && off == STATUS_OFF && ram_data_i[STATUS_EXPIRED_BIT]),
        .count_o    (tmr_count),
        .expired_o  (tmr_expired)
    );

    assign led_o = led_q;
    assign irq_o = tmr_expired;
`else
    assign mmio_sel = 1'b0;
    assign rd_word  = mem_q[idx];
    assign led_o    = '0;
    assign irq_o    = 1'b0;
`endif

    assign ram_data_o = (acc_vld && !ram_we_i) ? rd_word : '0;
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed + randomized accesses checked against an edge-counting reference model.
module tb_data_ram_resp;
    localparam int AW    = 10;
    localparam int LW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [31:0]   addr = '0, wdata = '0;
    logic          we = 1'b0;
    logic [3:0]    sel = '0, ce = '0;
    logic [31:0]   ram_data_o;
    logic [LW-1:0] led_o;
    logic          irq_o;

    int vecs = 0;
    int errs = 0;

    // Reference model: words plus full-word validity, and peripherals in terms of edges since reset.
    logic [31:0]   mem_m [DEPTH];
    bit            vld_m [DEPTH];
    longint        edges = 0;
    logic [LW-1:0] led_m = '0;
    longint        deadline = 0;
    bit            t_act = 0;
    bit            exp_m = 0;

    data_ram_resp #(.RAM_AW(AW), .LED_W(LW)) dut (
        .clk        (clk),
        .clr        (clr),
        .ram_addr_i (addr),
        .ram_data_i (wdata),
        .ram_we_i   (we),
        .ram_sel_i  (sel),
        .ram_ce_i   (ce),
        .ram_data_o (ram_data_o),
        .led_o      (led_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_read(input logic [31:0] a, input logic w, input logic [3:0] c,
                                       output logic [31:0] v, output bit known);
        int i;
        i = int'(a[AW+1:2]);
        known = 1;
        v = '0;
        if (c == 4'd0 || w) return;
`ifdef DATA_RAM_MMIO_EN
        if (a[31:28] == 4'hF) begin
            case (a[7:0])
                8'h00:   v = 32'(led_m);
                8'h04:   v = edges[31:0];
                8'h08:   v = t_act ? 32'(deadline - edges) : 32'd0;
                8'h0C:   v = {31'd0, exp_m};
                default: v = '0;
            endcase
            return;
        end
`endif
        known = vld_m[i];
        v = mem_m[i];
    endfunction

    function automatic void model_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                                       input logic [3:0] s, input logic [3:0] c);
        longint      e;
        bit          wr;
        int          i;
        logic [31:0] m;
        e  = edges + 1;
        wr = (c != 4'd0) && w;
        i  = int'(a[AW+1:2]);
        m  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`ifdef DATA_RAM_MMIO_EN
        begin
            bit ld, cl, fire;
            ld = 0;
            cl = 0;
            if (wr && a[31:28] == 4'hF) begin
                if (a[7:0] == 8'h00) led_m = LW'((32'(led_m) & ~m) | (d & m));
                ld = a[7:0] == 8'h08;
                cl = a[7:0] == 8'h0C && d[0];
                wr = 0;
            end
            fire = t_act && deadline == e;
            if (ld) begin
                deadline = e + longint'(d);
                t_act = d != 0;
            end else if (fire) t_act = 0;
            exp_m = (fire && !ld) ? 1'b1 : (cl ? 1'b0 : exp_m);
        end
`endif
        if (wr) begin
            mem_m[i] = (mem_m[i] & ~m) | (d & m);
            vld_m[i] = vld_m[i] || s == 4'hF;
        end
        edges = e;
    endfunction

    function automatic void model_reset();
        edges = 0;
        led_m = '0;
        t_act = 0;
        exp_m = 0;
    endfunction

    // One access per cycle: drive after an edge, check at the negedge, commit at the next edge.
    task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [3:0] s, input logic [3:0] c, output logic [31:0] rd);
        logic [31:0] exp_rd;
        bit          known;
        addr = a; wdata = d; we = w; sel = s; ce = c;
        @(negedge clk);
        rd = ram_data_o;
        model_read(a, w, c, exp_rd, known);
        if (known) chk("rdata", rd, exp_rd);
        chk("led_o", 32'(led_o), 32'(led_m));
        chk("irq_o", 32'(irq_o), 32'(exp_m));
        @(posedge clk);
        if (clr) model_edge(a, d, w, s, c);
        #1;
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        for (int k = 0; k < n; k++) acc('0, '0, 1'b0, 4'h0, 4'h0, rd);
    endtask

    initial begin
        logic [31:0] rd, r1, r2, a, d;
        logic [3:0]  s, c;
        logic        w;
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", 32'(led_o), 32'd0);
        chk("reset_irq", 32'(irq_o), 32'd0);
        clr = 1'b1;

        acc(32'h0000_0010, 32'h1122_3344, 1'b1, 4'hF, 4'hF, rd);
        acc(32'h0000_0010, 32'hAABB_CCDD, 1'b1, 4'h5, 4'h1, rd);
        acc(32'h0000_0010, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("byte_lanes", rd, 32'h11BB_33DD);
        acc(32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 4'h0, 4'hF, rd);
        acc(32'h0000_0010, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("sel_zero", rd, 32'h11BB_33DD);

        acc(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 4'hF, 4'h2, rd);
        acc(32'h0000_0000 + 4 * DEPTH, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("alias", rd, 32'hDEAD_BEEF);
        acc(32'h0000_0000, '0, 1'b0, 4'hF, 4'h0, rd);
        chk("ce_zero", rd, 32'd0);
        acc(32'h0000_0000, '0, 1'b1, 4'h0, 4'hF, rd);
        chk("we_read", rd, 32'd0);

`ifdef DATA_RAM_MMIO_EN
        acc(32'hF000_0000, 32'h0000_A5A5, 1'b1, 4'hF, 4'hF, rd);
        chk("led_write", 32'(led_o), 32'h0000_A5A5);
        acc(32'hF000_0004, '0, 1'b0, 4'hF, 4'hF, r1);
        idle(9);
        acc(32'hF000_0004, '0, 1'b0, 4'hF, 4'hF, r2);
        chk("cycle_delta", r2 - r1, 32'd10);
        acc(32'hF000_0004, 32'h0000_0000, 1'b1, 4'hF, 4'hF, rd);
        acc(32'hF000_0004, '0, 1'b0, 4'hF, 4'hF, r2);
        chk("cycle_ro", r2 - r1, 32'd12);

        acc(32'hF000_0008, 32'd5, 1'b1, 4'h0, 4'hF, rd);
        idle(4);
        chk("irq_before", 32'(irq_o), 32'd0);
        idle(1);
        chk("irq_at_5", 32'(irq_o), 32'd1);
        acc(32'hF000_000C, 32'd1, 1'b1, 4'hF, 4'hF, rd);
        chk("irq_clear", 32'(irq_o), 32'd0);

        acc(32'hF000_0008, 32'd3, 1'b1, 4'hF, 4'hF, rd);
        idle(2);
        acc(32'hF000_0008, 32'd4, 1'b1, 4'hF, 4'hF, rd);
        chk("reload_wins", 32'(irq_o), 32'd0);
        idle(3);
        chk("reload_pend", 32'(irq_o), 32'd0);
        idle(1);
        chk("reload_fire", 32'(irq_o), 32'd1);
        acc(32'hF000_000C, 32'd1, 1'b1, 4'hF, 4'hF, rd);

        acc(32'hF000_0000, 32'h0000_FFFF, 1'b1, 4'hF, 4'hF, rd);
        acc(32'hF000_0008, 32'd3, 1'b1, 4'hF, 4'hF, rd);
        addr = 32'hF000_0004; we = 1'b0; ce = 4'hF; sel = 4'hF;
`else
        acc(32'hF000_0000, 32'h1234_5678, 1'b1, 4'hF, 4'hF, rd);
        acc(32'h0000_0000, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("no_mmio_word0", rd, 32'h1234_5678);
        chk("no_mmio_led", 32'(led_o), 32'd0);
        addr = 32'h0000_0010; we = 1'b0; ce = 4'hF; sel = 4'hF;
`endif
        #3;
        clr = 1'b0;
        #1;
        chk("midrst_led", 32'(led_o), 32'd0);
        chk("midrst_irq", 32'(irq_o), 32'd0);
`ifdef DATA_RAM_MMIO_EN
        chk("midrst_cycle", ram_data_o, 32'd0);
`else
        chk("midrst_ram", ram_data_o, 32'h11BB_33DD);
`endif
        model_reset();
        @(posedge clk);
        #1;
        clr = 1'b1;
`ifdef DATA_RAM_MMIO_EN
        acc(32'hF000_0004, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("post_cycle", rd, 32'd0);
        acc(32'hF000_0008, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("post_timer", rd, 32'd0);
`endif
        acc(32'h0000_0010, '0, 1'b0, 4'hF, 4'hF, rd);
        chk("post_ram", rd, 32'h11BB_33DD);
        idle(5);
        chk("post_irq", 32'(irq_o), 32'd0);

        for (int n = 0; n < 600; n++) begin
            a = $urandom;
            a[AW+1:2] = AW'($urandom_range(0, 15));
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            c = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
`ifdef DATA_RAM_MMIO_EN
            if ($urandom_range(0, 2) == 0) begin
                a = {4'hF, 20'($urandom), 8'($urandom_range(0, 4) * 4)};
                if (a[7:0] == 8'h08) d = 32'($urandom_range(0, 6));
                if (a[7:0] == 8'h0C && $urandom_range(0, 3) != 0) w = 1'b0;
            end else if (a[31:28] == 4'hF) a[31] = 1'b0;
`endif
            acc(a, d, w, s, c, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/data_ram_resp.md
# data_ram_resp

Data-memory responder for the pipelined core's RAM port: accepts the core's address/data/write-enable/byte-select/chip-enable strobes and serves them from a word-organised on-chip RAM, with an optional memory-mapped peripheral window (LED register, free-running cycle counter, down-count timer with sticky expiry flag). Sits outside the core, on the opposite side of the core's RAM interface. Reads are combinational, because the core's MEM stage consumes read data in the same cycle with no stall path. Writes commit on the clock edge.

## Interface
Parameters:
- RAM_AW, 10, word-address width; RAM depth = 2^RAM_AW 32-bit words
- LED_W, 16, width of LED output register

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- ram_addr_i  in  32  byte address from core
- ram_data_i  in  32  write data from core
- ram_we_i  in  1  write enable (1 = write)
- ram_sel_i  in  4  byte-lane enables, bit i ↔ data bits [8i+7:8i]
- ram_ce_i  in  4  chip enable; access valid when ram_ce_i != 0
- ram_data_o  out  32  read data, combinational
- led_o  out  LED_W  LED register value
- irq_o  out  1  timer-expired flag (level)

## Operation
- Decode: ram_addr_i[31:28] == 4'hF selects the MMIO window; otherwise RAM, index = ram_addr_i[RAM_AW+1:2]. Upper bits are ignored, so addresses alias/wrap modulo RAM size. addr[1:0] is ignored.
- RAM write: ce valid, we=1, RAM selected → each lane with sel[i]=1 is updated at the edge; other lanes keep their value. sel=0 → no change.
- Read: ce valid, we=0 → ram_data_o = full selected word (core extracts bytes). ce=0 or we=1 → ram_data_o = 0.
- MMIO map (offset = addr[7:0]):
  - 0x00 LED: read/write, low LED_W bits, lane-masked by sel. Upper read bits are 0.
  - 0x04 CYCLE: read-only 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0. Writes are ignored.
  - 0x08 TIMER: a write loads the down-counter (full word, sel ignored). A read returns the current count.
  - 0x0C STATUS: bit0 = expired. Writing 1 to bit0 clears it. Other bits read 0.
  - Other offsets: read 0, writes ignored.
- Timer states:
  - IDLE (count 0) → a load with nonzero value enters RUN. A load of 0 stays in IDLE and does not set expired.
  - RUN: decrement each cycle. On the transition 1→0, set expired and return to IDLE.
  - A load during RUN restarts with the new value.
- Simultaneous events:
  - Load in the same cycle as 1→0: the load wins and expired is not set.
  - Expiry in the same cycle as a STATUS clear: set wins, expired stays 1.
- irq_o = expired.

## Timing
- Read latency 0 cycles (combinational from addr/ce/we).
- Write visible to a read in the cycle after the write edge. There is no same-cycle write-to-read bypass.
- Timer loaded with N asserts expired N cycles after the load edge.
- CYCLE reads 0 in the first cycle after reset release, then k after k edges.
- Reset (clr=0, any time, including mid-count):
  - led_o=0, CYCLE=0, timer count=0 (IDLE), expired=0, irq_o=0.
  - RAM contents are not reset (undefined until written).
  - ram_data_o follows the combinational rule.
- Accesses while clr=0 are ignored.

## Configuration
- DATA_RAM_MMIO_EN defined:
  - MMIO window, LED, CYCLE, timer and irq are present as above.
- DATA_RAM_MMIO_EN undefined:
  - No address decode; the whole address space maps to RAM by index bits.
  - led_o tied 0, irq_o tied 0.
  - No counter or timer flops.

## Structure
- Package data_ram_pkg holds:
  - MMIO_BASE nibble 4'hF
  - offsets LED_OFF/CYCLE_OFF/TIMER_OFF/STATUS_OFF
  - STATUS_EXPIRED_BIT
  - timer state typedef {IDLE, RUN}
- Sub-module data_ram_timer: 32-bit down-counter, load/clear inputs, expired output. Instantiated only under DATA_RAM_MMIO_EN.
- RAM array and lane-masked write stay in the top module.

## Test plan
- Byte lanes: write 0x11223344 to 0x0000_0010 with sel=4'b1111, then write 0xAABBCCDD with sel=4'b0101 → read 0x0000_0010 returns 0x11BB33DD.
- Aliasing: write 0xDEADBEEF to 0x0000_0000 → read at 0x0000_0000 + 4·2^RAM_AW returns 0xDEADBEEF. A read with ce=0 returns 0.
- MMIO LED/CYCLE: write 0x0000_A5A5 to 0xF000_0000 → led_o=16'hA5A5. Two reads of 0xF000_0004, 10 cycles apart, differ by 10. A write to CYCLE leaves it unchanged.
- Timer:
  - Load 5 at 0xF000_0008 → irq_o rises exactly 5 cycles after the load edge.
  - Write 1 to 0xF000_000C → irq_o=0 next cycle.
  - A reload in the expiry cycle suppresses irq.
- Reset mid-operation: timer at 3, LED=0xFFFF, drop clr asynchronously between edges → led_o, irq_o and CYCLE read 0 immediately. After release the timer is IDLE and RAM contents are unchanged.
- With DATA_RAM_MMIO_EN undefined: a write to 0xF000_0000 lands in RAM word 0 and reads back. led_o=0 and irq_o=0 throughout.
